// File: rtl/usb4_lane_clk_en_gen_if.sv
// Bundle of configuration, enable and strobe signals for usb4_lane_clk_en_gen.
// The generator uses the slave modport; whatever drives it uses master.
interface usb4_lane_clk_en_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24,
  parameter int SEL_W  = 2
);
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_wr;
  logic [SEL_W-1:0]  cfg_addr;
  logic [ACC_W-1:0]  cfg_data;
  logic [SEL_W-1:0]  gen_sel;
  logic              align;
  logic [NUM_CH-1:0] stb;
  logic [NUM_CH-1:0] ch_rst;
  logic              lane_stb;

  modport master (
    output ch_en, cfg_wr, cfg_addr, cfg_data, gen_sel, align,
    input  stb, ch_rst, lane_stb
  );

  modport slave (
    input  ch_en, cfg_wr, cfg_addr, cfg_data, gen_sel, align,
    output stb, ch_rst, lane_stb
  );
endinterface

// File: rtl/usb4_lane_clk_en_gen.sv
// Multi-channel fractional clock-enable generator with per-channel reset sequencing.
// Define USB4_CLKEN_ALIGN_EN to let the align input zero every channel's phase accumulator.
module usb4_lane_clk_en_gen #(
  parameter int NUM_CH   = 4,
  parameter int ACC_W    = 24,
  parameter int HOLD_STB = 3,
  parameter int SEL_W    = 2
) (
  input logic                   local_clk,
  input logic                   rst,
  usb4_lane_clk_en_gen_if.slave bus
);

  localparam int              HC_W      = (HOLD_STB > 1) ? $clog2(HOLD_STB) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_STB - 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_HOLD     = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  state_e            r_state    [NUM_CH];
  logic [ACC_W-1:0]  r_acc      [NUM_CH];
  logic [ACC_W-1:0]  r_inc      [NUM_CH];
  logic [HC_W-1:0]   r_hold_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_stb;
  logic [NUM_CH-1:0] r_ch_rst;

  state_e            w_state_nxt    [NUM_CH];
  logic [ACC_W-1:0]  w_acc_nxt      [NUM_CH];
  logic [HC_W-1:0]   w_hold_cnt_nxt [NUM_CH];
  logic [ACC_W:0]    w_sum          [NUM_CH];
  logic [NUM_CH-1:0] w_stb_nxt;
  logic [NUM_CH-1:0] w_ch_rst_nxt;
  logic              w_lane_stb;

  // One extra bit on the add: the carry out of the accumulator is the strobe.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
    assign w_sum[g] = {1'b0, r_acc[g]} + {1'b0, r_inc[g]};
  end

`ifndef USB4_CLKEN_ALIGN_EN
  logic w_unused_align;
  assign w_unused_align = bus.align;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_stb_nxt    = '0;
    w_ch_rst_nxt = r_ch_rst;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_acc_nxt[i]      = r_acc[i];
      w_hold_cnt_nxt[i] = r_hold_cnt[i];

      case (r_state[i])
        ST_HOLD, ST_RUN: begin
          if (!bus.ch_en[i]) begin
            w_state_nxt[i]    = ST_DISABLED;
            w_acc_nxt[i]      = '0;
            w_hold_cnt_nxt[i] = '0;
            w_ch_rst_nxt[i]   = 1'b1;
          end
`ifdef USB4_CLKEN_ALIGN_EN
          else if (bus.align) begin
            w_acc_nxt[i] = '0;
            w_stb_nxt[i] = 1'b0;
          end
`endif
          else begin
            w_acc_nxt[i] = w_sum[i][ACC_W-1:0];
            w_stb_nxt[i] = w_sum[i][ACC_W];
            // Count strobes already on the output; the last one releases the channel reset.
            if (r_state[i] == ST_HOLD && r_stb[i]) begin
              if (r_hold_cnt[i] == HOLD_LAST) begin
                w_state_nxt[i]  = ST_RUN;
                w_ch_rst_nxt[i] = 1'b0;
              end else begin
                w_hold_cnt_nxt[i] = r_hold_cnt[i] + HC_W'(1);
              end
            end
          end
        end

        default: begin
          w_acc_nxt[i]      = '0;
          w_hold_cnt_nxt[i] = '0;
          w_ch_rst_nxt[i]   = 1'b1;
          if (bus.ch_en[i]) begin
            w_state_nxt[i] = ST_HOLD;
          end else begin
            w_state_nxt[i] = ST_DISABLED;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge local_clk) begin
    if (rst) begin
      // NOTE: the increment register file is reset because an unwritten channel must produce no strobes.
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= ST_DISABLED;
        r_acc[i]      <= '0;
        r_inc[i]      <= '0;
        r_hold_cnt[i] <= '0;
      end
      r_stb    <= '0;
      r_ch_rst <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_acc[i]      <= w_acc_nxt[i];
        r_hold_cnt[i] <= w_hold_cnt_nxt[i];
        if (bus.cfg_wr && int'(bus.cfg_addr) == i) begin
          r_inc[i] <= bus.cfg_data;
        end
      end
      r_stb    <= w_stb_nxt;
      r_ch_rst <= w_ch_rst_nxt;
    end
  end

  // Out-of-range selects match no channel and leave the lane strobe low.
  always_comb begin
    w_lane_stb = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.gen_sel) == i) begin
        w_lane_stb = r_stb[i];
      end
    end
  end

  assign bus.stb      = r_stb;
  assign bus.ch_rst   = r_ch_rst;
  assign bus.lane_stb = w_lane_stb;

endmodule

// File: tb/tb_usb4_lane_clk_en_gen.sv
// Directed bench for usb4_lane_clk_en_gen; NUM_CH=3 so that select/address value 3 is out of range.
module tb_usb4_lane_clk_en_gen;
  localparam int NUM_CH   = 3;
  localparam int ACC_W    = 24;
  localparam int HOLD_STB = 3;
  localparam int SEL_W    = 2;

  logic local_clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  usb4_lane_clk_en_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SEL_W(SEL_W)) bus ();

  usb4_lane_clk_en_gen #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .HOLD_STB(HOLD_STB),
    .SEL_W   (SEL_W)
  ) dut (
    .local_clk(local_clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  always #5 local_clk = ~local_clk;

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_inc(input int ch, input logic [ACC_W-1:0] val);
    bus.cfg_addr = SEL_W'(ch);
    bus.cfg_data = val;
    bus.cfg_wr   = 1'b1;
    tick();
    bus.cfg_wr   = 1'b0;
  endtask

  // Edge 0 is the one just taken; strobes land every `period` edges, reset drops one edge after the last held strobe.
  task automatic expect_hold(input string tag, input int ch, input int period);
    for (int j = 1; j <= HOLD_STB * period + 1; j++) begin
      tick();
      check($sformatf("%s_stb_%0d", tag, j), 32'(bus.stb[ch]), 32'(j % period == 0));
      check($sformatf("%s_rst_%0d", tag, j), 32'(bus.ch_rst[ch]), 32'(j <= HOLD_STB * period));
    end
  endtask

  initial begin
    int bad;
    int c0, c1, c2;
    logic e0, e1;

    rst          = 1'b1;
    bus.ch_en    = '0;
    bus.cfg_wr   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.gen_sel  = '0;
    bus.align    = 1'b0;
    tick();
    tick();
    check("rst_stb", 32'(bus.stb), 32'h0);
    check("rst_ch_rst", 32'(bus.ch_rst), 32'h7);
    check("rst_lane", 32'(bus.lane_stb), 32'h0);

    // 10G channel: strobe every 8 cycles, reset released after three of them.
    rst = 1'b0;
    write_inc(0, 24'h20_0000);
    bus.ch_en = 3'b001;
    tick();
    check("t1_enter_stb", 32'(bus.stb[0]), 32'h0);
    check("t1_enter_rst", 32'(bus.ch_rst[0]), 32'h1);
    expect_hold("t1", 0, 8);

    // Lane select follows the mux immediately.
    write_inc(1, 24'h40_0000);
    write_inc(2, 24'h80_0000);
    bus.ch_en   = 3'b111;
    bus.gen_sel = 2'd2;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      check($sformatf("t2_sel2_%0d", j), 32'(bus.lane_stb), 32'(j % 2 == 0));
    end
    bus.gen_sel = 2'd1;
    #1;
    check("t2_switch", 32'(bus.lane_stb), 32'h1);
    for (int j = 9; j <= 16; j++) begin
      tick();
      check($sformatf("t2_sel1_%0d", j), 32'(bus.lane_stb), 32'(j % 4 == 0));
    end
    bus.gen_sel = 2'd3;
    for (int j = 17; j <= 20; j++) begin
      tick();
      check($sformatf("t2_sel3_%0d", j), 32'(bus.lane_stb), 32'h0);
    end
    check("t2_all_run", 32'(bus.ch_rst), 32'h0);

    // Drop and re-enable channel 0 from RUN.
    bus.ch_en = 3'b110;
    tick();
    check("t3_drop_stb", 32'(bus.stb[0]), 32'h0);
    check("t3_drop_rst", 32'(bus.ch_rst), 32'h1);
    bus.ch_en = 3'b111;
    tick();
    check("t3_reen_rst", 32'(bus.ch_rst[0]), 32'h1);
    expect_hold("t3", 0, 8);

    // Zero increment parks the channel in HOLD until a real increment arrives.
    bus.ch_en = 3'b011;
    tick();
    write_inc(2, 24'h0);
    bus.ch_en = 3'b111;
    tick();
    bad = 0;
    repeat (1000) begin
      tick();
      if (bus.ch_rst[2] !== 1'b1 || bus.stb[2] !== 1'b0) bad++;
    end
    check("t4_parked", 32'(bad), 32'h0);
    write_inc(2, 24'h80_0000);
    expect_hold("t4", 2, 2);

    // Out-of-range address: all three rates must be unchanged.
    write_inc(3, 24'h0);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (8) begin
      tick();
      c0 += int'(bus.stb[0]);
      c1 += int'(bus.stb[1]);
      c2 += int'(bus.stb[2]);
    end
    check("t5_cnt0", 32'(c0), 32'd1);
    check("t5_cnt1", 32'(c1), 32'd2);
    check("t5_cnt2", 32'(c2), 32'd4);

    // Reset in the middle of a HOLD phase.
    bus.ch_en = 3'b110;
    tick();
    bus.ch_en = 3'b111;
    tick();
    repeat (10) tick();
    check("t5_midhold", 32'(bus.ch_rst[0]), 32'h1);
    bus.gen_sel = 2'd2;
    rst = 1'b1;
    tick();
    check("t5_rst_stb", 32'(bus.stb), 32'h0);
    check("t5_rst_ch_rst", 32'(bus.ch_rst), 32'h7);
    check("t5_rst_lane", 32'(bus.lane_stb), 32'h0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.stb !== 3'b000 || bus.ch_rst !== 3'b111) bad++;
    end
    check("t5_inc_cleared", 32'(bad), 32'h0);

    // Align pulse at edge k+7 after enable; without the feature the original phase continues.
    bus.ch_en = 3'b000;
    tick();
    write_inc(0, 24'h20_0000);
    write_inc(1, 24'h40_0000);
    bus.ch_en = 3'b011;
    tick();
    repeat (6) tick();
    bus.align = 1'b1;
    tick();
    bus.align = 1'b0;
    check("t6_align_edge", 32'(bus.stb[1:0]), 32'h0);
    for (int j = 1; j <= 8; j++) begin
      tick();
`ifdef USB4_CLKEN_ALIGN_EN
      e1 = (j == 4) || (j == 8);
      e0 = (j == 8);
`else
      e1 = (j == 1) || (j == 5);
      e0 = (j == 1);
`endif
      check($sformatf("t6_stb_%0d", j), 32'(bus.stb[1:0]), 32'({e1, e0}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
